// File: rtl/arbitrated_mux_pkg.sv
// Shared definitions for arbitrated_mux: index sizing, FIFO geometry and the
// packet-lock state encoding.
package arbitrated_mux_pkg;

  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned COUNT_WIDTH = 2;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits in one FIFO entry: payload, last flag and source index.
  function automatic int unsigned entry_width(input int unsigned data_w,
                                              input int unsigned index_w);
    return data_w + 1 + index_w;
  endfunction

endpackage

// File: rtl/arbitrated_mux_fifo.sv
// Two-entry synchronous FIFO with registered storage; the head entry is read
// straight from storage so there is no input-to-output bypass.
module arbitrated_mux_fifo
  import arbitrated_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                             wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0]           count_q, count_d;
  logic                             push_ok, pop_ok;

  assign o_full  = (count_q == COUNT_WIDTH'(FIFO_DEPTH));
  assign o_empty = (count_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/arbitrated_mux.sv
// Steers one beat per cycle from the externally granted source into a 2-entry
// output FIFO, holding the grant on one source until its packet's last beat.
module arbitrated_mux
  import arbitrated_mux_pkg::*;
#(
  parameter int unsigned  REQUEST_WIDTH = 8,
  parameter int unsigned  DATA_WIDTH    = 32,
  localparam int unsigned INDEX_WIDTH   = index_width(REQUEST_WIDTH)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [REQUEST_WIDTH-1:0]               i_valid,
  output logic [REQUEST_WIDTH-1:0]               o_ready,
  input  logic [REQUEST_WIDTH-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [REQUEST_WIDTH-1:0]               i_last,
  output logic [REQUEST_WIDTH-1:0]               o_request,
  input  logic [INDEX_WIDTH-1:0]                 i_grant,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [DATA_WIDTH-1:0]                  o_data,
  output logic                                   o_last,
  output logic [INDEX_WIDTH-1:0]                 o_source
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   last;
    logic [INDEX_WIDTH-1:0] source;
  } entry_t;

  localparam int unsigned EntryBits = entry_width(DATA_WIDTH, INDEX_WIDTH);

  lock_state_e              lock_state_q;
  logic [INDEX_WIDTH-1:0]   lock_idx_q;

  logic [COUNT_WIDTH-1:0]   fifo_count;
  logic                     fifo_full, fifo_empty;
  logic                     space, in_range, accept, pop;
  logic [REQUEST_WIDTH-1:0] grant_onehot, lock_mask, request;
  entry_t                   push_entry, head;

  // Reset gates space so no source sees o_ready while the block is held.
  assign space    = i_rst_n && (fifo_count < COUNT_WIDTH'(FIFO_DEPTH));
  assign in_range = (32'(i_grant) < REQUEST_WIDTH);

  always_comb begin
    grant_onehot = '0;
    if (in_range) begin
      grant_onehot = REQUEST_WIDTH'(1) << i_grant;
    end
  end

  always_comb begin
    lock_mask = '1;
    if (lock_state_q == StLocked) begin
      lock_mask = REQUEST_WIDTH'(1) << lock_idx_q;
    end
  end

  assign request   = space ? (i_valid & lock_mask) : '0;
  assign accept    = |(request & grant_onehot);
  assign o_request = request;
  assign o_ready   = accept ? grant_onehot : '0;

  always_comb begin
    push_entry        = '0;
    push_entry.source = i_grant;
    if (in_range) begin
      push_entry.data = i_data[i_grant];
      push_entry.last = i_last[i_grant];
    end
  end

  // Packet lock: any accepted non-last beat pins arbitration to its source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_state_q <= StUnlocked;
      lock_idx_q   <= '0;
    end else if (accept) begin
      unique case (push_entry.last)
        1'b1: lock_state_q <= StUnlocked;
        1'b0: begin
          lock_state_q <= StLocked;
          lock_idx_q   <= i_grant;
        end
        default: lock_state_q <= lock_state_q;
      endcase
    end
  end

  assign pop = !fifo_empty && i_ready;

  arbitrated_mux_fifo #(
    .WIDTH (EntryBits)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (accept),
    .i_data  (push_entry),
    .i_pop   (pop),
    .o_data  (head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid  = !fifo_empty;
  assign o_data   = head.data;
  assign o_last   = head.last;
  assign o_source = head.source;

`ifndef SYNTHESIS
  // The arbiter must answer a live request with an in-range, requesting index.
  grant_valid_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (|o_request) |-> (in_range && request[i_grant]));

  no_push_when_full_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(accept && fifo_full));
`endif

endmodule

// File: tb/tb_arbitrated_mux.sv
// Scoreboard bench for arbitrated_mux driven by a round-robin arbiter model.
module tb_arbitrated_mux;

  localparam int RW = 8;
  localparam int DW = 32;
  localparam int IW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] src;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [RW-1:0]         i_valid, o_ready, i_last, o_request;
  logic [RW-1:0][DW-1:0] i_data;
  logic [IW-1:0]         i_grant, rr_ptr;
  logic                  o_valid, i_ready, o_last;
  logic [DW-1:0]         o_data;
  logic [IW-1:0]         o_source;

  exp_t          exp_q[$];
  beat_t         src_q[RW][$];
  logic [RW-1:0] acc;
  int            n_checks = 0;
  int            n_fails  = 0;

  arbitrated_mux #(
    .REQUEST_WIDTH (RW),
    .DATA_WIDTH    (DW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_last    (i_last),
    .o_request (o_request),
    .i_grant   (i_grant),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_source  (o_source)
  );

  always #5 i_clk = ~i_clk;

  // Round-robin arbiter: first requester at or after the pointer wins.
  always_comb begin
    i_grant = '0;
    for (int k = RW - 1; k >= 0; k--) begin
      if (o_request[rr_ptr + IW'(k)]) i_grant = rr_ptr + IW'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr <= '0;
    else if (|o_request) rr_ptr <= i_grant + IW'(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic last, input int gap);
    beat_t b;
    b.data = d;
    b.last = last;
    b.gap  = gap;
    src_q[s].push_back(b);
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic last, input int s);
    exp_t e;
    e.data = d;
    e.last = last;
    e.src  = IW'(s);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge i_clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Source driver: inputs change at negedge+1, handshake captured at negedge+4.
  initial begin
    int wait_cnt[RW];
    bit fresh[RW];
    acc     = '0;
    i_valid = '0;
    i_data  = '0;
    i_last  = '0;
    for (int s = 0; s < RW; s++) begin
      wait_cnt[s] = 0;
      fresh[s]    = 1'b1;
    end
    forever begin
      @(negedge i_clk);
      #1;
      for (int s = 0; s < RW; s++) begin
        if (acc[s] && src_q[s].size() != 0) begin
          void'(src_q[s].pop_front());
          fresh[s] = 1'b1;
        end
        if (src_q[s].size() == 0) fresh[s] = 1'b1;
        else if (fresh[s]) begin
          wait_cnt[s] = src_q[s][0].gap;
          fresh[s]    = 1'b0;
        end
        i_valid[s] = 1'b0;
        i_data[s]  = '0;
        i_last[s]  = 1'b0;
        if (src_q[s].size() != 0) begin
          if (wait_cnt[s] > 0) wait_cnt[s]--;
          else begin
            i_valid[s] = 1'b1;
            i_data[s]  = src_q[s][0].data;
            i_last[s]  = src_q[s][0].last;
          end
        end
      end
      #3;
      acc = o_ready;
      check("ready_without_valid", 64'(o_ready & ~i_valid), 64'd0);
      check("ready_not_onehot", 64'($countones(o_ready) > 1), 64'd0);
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t got;
    forever begin
      @(negedge i_clk);
      #4;
      if (i_rst_n && o_valid && i_ready) begin
        got = {o_data, o_last, o_source};
        check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("beat", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int  cnt;
    bit  found;
    i_rst_n = 1'b0;
    i_ready = 1'b1;

    // Reset with every source valid, then a fair single-beat stream.
    for (int s = 0; s < RW; s++)
      for (int n = 0; n < 8; n++) add_beat(s, DW'(s * 'h100 + n), 1'b1, 0);
    for (int k = 0; k < 64; k++) expect_beat(DW'((k % 8) * 'h100 + k / 8), 1'b1, k % 8);
    repeat (5) begin
      @(negedge i_clk);
      #4;
      check("reset_o_valid", 64'(o_valid), 64'd0);
      check("reset_o_ready", 64'(o_ready), 64'd0);
      check("reset_outputs", 64'({o_data, o_last, o_source}), 64'd0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #4;
    check("first_accept", 64'(o_ready), 64'h01);
    check("first_latency", 64'(o_valid), 64'd0);
    cnt = 0;
    repeat (64) begin
      @(negedge i_clk);
      #4;
      cnt += int'(o_valid);
    end
    check("stream_no_gaps", 64'(cnt), 64'd64);
    wait_drain("drain_fairness");

    // Lock: 4-beat src2 packet while src5 waits.
    @(negedge i_clk);
    for (int n = 0; n < 4; n++) add_beat(2, DW'('h2000 + n), n == 3, 0);
    add_beat(5, 'h5000, 1'b1, 0);
    for (int n = 0; n < 4; n++) expect_beat(DW'('h2000 + n), n == 3, 2);
    expect_beat('h5000, 1'b1, 5);
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge i_clk);
      #4;
      check("lock_ready", 64'(o_ready), (c < 4) ? 64'h04 : 64'h20);
    end
    wait_drain("drain_lock");

    // Backpressure: FIFO fills with two beats then requests stop.
    @(negedge i_clk);
    i_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      add_beat(7, DW'('hB700 + n), 1'b1, 0);
      add_beat(0, DW'('hB000 + n), 1'b1, 0);
    end
    for (int n = 0; n < 3; n++) begin
      expect_beat(DW'('hB700 + n), 1'b1, 7);
      expect_beat(DW'('hB000 + n), 1'b1, 0);
    end
    for (int c = 1; c <= 10; c++) begin
      if (c != 1) @(negedge i_clk);
      #4;
      if (c == 1) check("bp_first_request", 64'(o_request), 64'h81);
      if (c >= 3) check("bp_request_zero", 64'(o_request), 64'd0);
    end
    check("bp_buffered", 64'(src_q[7].size() + src_q[0].size()), 64'd4);
    check("bp_head_valid", 64'(o_valid), 64'd1);
    @(negedge i_clk);
    i_ready = 1'b1;
    wait_drain("drain_backpressure");

    // Lock stall: src3 drops valid for 3 cycles mid-packet, src4 must wait.
    @(negedge i_clk);
    add_beat(3, 'h3000, 1'b0, 0);
    add_beat(3, 'h3001, 1'b0, 3);
    add_beat(3, 'h3002, 1'b1, 0);
    add_beat(4, 'h4000, 1'b1, 0);
    expect_beat('h3000, 1'b0, 3);
    expect_beat('h3001, 1'b0, 3);
    expect_beat('h3002, 1'b1, 3);
    expect_beat('h4000, 1'b1, 4);
    #4;
    check("stall_first", 64'(o_ready), 64'h08);
    for (int c = 1; c <= 4; c++) begin
      @(negedge i_clk);
      #4;
      if (c < 4) check("stall_request_zero", 64'(o_request), 64'd0);
      else check("stall_resume", 64'(o_ready), 64'h08);
    end
    wait_drain("drain_stall");

    // Reset mid-packet after beat 2 of a 5-beat src1 packet.
    @(negedge i_clk);
    for (int n = 0; n < 5; n++) add_beat(1, DW'('h1000 + n), n == 4, 0);
    expect_beat('h1000, 1'b0, 1);
    expect_beat('h1001, 1'b0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_clk);
      #2;
      if (src_q[1].size() == 3) found = 1'b1;
    end
    check("midreset_trigger", 64'(found), 64'd1);
    i_rst_n = 1'b0;
    #2;
    check("midreset_o_valid", 64'(o_valid), 64'd0);
    check("midreset_o_ready", 64'(o_ready), 64'd0);
    exp_q.delete();
    src_q[1].delete();
    @(negedge i_clk);
    add_beat(6, 'h6000, 1'b1, 0);
    expect_beat('h6000, 1'b1, 6);
    i_rst_n = 1'b1;
    #4;
    check("post_reset_grant6", 64'(o_ready), 64'h40);
    check("post_reset_empty", 64'(o_valid), 64'd0);
    wait_drain("drain_post_reset");

    @(negedge i_clk);
    #4;
    check("final_idle", 64'(o_valid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
